// File: rtl/seven_segment_scan.sv
// Time-multiplexed driver for a bank of common-anode hex 7-segment digits.
// It scans one digit per slot and holds a load-strobed display register.
// Each digit has its own decimal point, and leading zeros can be blanked.
// Brightness is set by PWM within each slot, and selected digits can blink.
// All outputs are registered.
module seven_segment_scan #(
    parameter int DIGITS     = 8,
    parameter int DIV_BITS   = 18,
    parameter int PWM_BITS   = 4,
    parameter int BLINK_BITS = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [4*DIGITS-1:0]   num_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [DIGITS-1:0]     an_out,
    output logic [7:0]            c_out,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [DIV_BITS-1:0]   pre;
    logic [IDX_W-1:0]      idx;
    logic [BLINK_BITS-1:0] frame_cnt;
    logic                  ph;
    logic                  wrap_q;
    logic [4*DIGITS-1:0]   num_reg;
    logic [DIGITS-1:0]     dp_reg;

    logic                  slot_end;
    logic                  wrap;
    logic [PWM_BITS-1:0]   pwm_field;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blink;
    logic                  cur_lz;
    logic                  lead_zero;
    logic [DIGITS-1:0]     an_lit;
    logic [6:0]            seg;
    logic                  blank;

    assign slot_end  = &pre;
    assign wrap      = slot_end && (idx == LAST_IDX);
    assign pwm_field = pre[DIV_BITS-1 -: PWM_BITS];

    // Display register: captures the digits and decimal points only on load.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            num_reg <= '0;
            dp_reg  <= '0;
        end else if (load) begin
            num_reg <= num_in;
            dp_reg  <= dp_in;
        end
    end

    // Scan timing: prescaler, digit index, frame counter and blink phase.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pre       <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            ph        <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            pre    <= pre + 1'b1;
            wrap_q <= wrap;
            if (slot_end) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end
            if (wrap) begin
                frame_cnt <= frame_cnt + 1'b1;
                if (&frame_cnt) begin
                    ph <= ~ph;
                end
            end
        end
    end

    // Select the current digit's data.
    // Leading-zero status is built by walking from the most significant digit downwards.
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        lead_zero = 1'b1;
        an_lit    = '1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            lead_zero = lead_zero && (num_reg[4*(DIGITS-1-k) +: 4] == 4'h0);
            if (idx == IDX_W'(DIGITS - 1 - k)) begin
                cur_lz = lead_zero;
            end
            if (idx == IDX_W'(k)) begin
                cur_nib   = num_reg[4*k +: 4];
                cur_dp    = dp_reg[k];
                cur_blink = blink_mask[k];
                an_lit[k] = 1'b0;
            end
        end
    end

    // Active-low hex decode for segments a..g.
    always_comb begin
        seg = 7'h7F;
        case (cur_nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

    // Blank the digit when any of these holds:
    // dead cycle, PWM off-phase, blink off-phase, or leading zero.
    always_comb begin
        blank = (pre == '0)
             || (pwm_field > brightness)
             || (cur_blink && ph)
             || (blank_lz && (idx != '0) && cur_lz);
    end

    // Output register: anodes, cathodes and the frame pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            an_out     <= '1;
            c_out      <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap_q;
            if (blank) begin
                an_out <= '1;
                c_out  <= 8'hFF;
            end else begin
                an_out <= an_lit;
                c_out  <= {~cur_dp, seg};
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan with DIGITS=4, DIV_BITS=4, PWM_BITS=2, BLINK_BITS=1.
// Stimulus pushes expected per-cycle outputs into a queue, and a negedge monitor pops and compares them.
module tb_seven_segment_scan;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] num_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [1:0]  brightness = 2'd3;
    logic [3:0]  an_out;
    logic [7:0]  c_out;
    logic        frame_done;

    seven_segment_scan #(
        .DIGITS(4),
        .DIV_BITS(4),
        .PWM_BITS(2),
        .BLINK_BITS(1)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .num_in(num_in),
        .dp_in(dp_in),
        .load(load),
        .blank_lz(blank_lz),
        .blink_mask(blink_mask),
        .brightness(brightness),
        .an_out(an_out),
        .c_out(c_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          q_cyc[$];
    logic [3:0]  q_an[$];
    logic [7:0]  q_c[$];
    logic        q_fd[$];
    string       q_tag[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int          base = 0;
    string       cur_tag = "reset";
    logic [7:0]  sc_seg [4];
    int          sc_bright = 3;
    logic [3:0]  sc_blink = '0;

    task automatic push_exp(input int c, input logic [3:0] an, input logic [7:0] cc, input logic fd);
        q_cyc.push_back(c);
        q_an.push_back(an);
        q_c.push_back(cc);
        q_fd.push_back(fd);
        q_tag.push_back(cur_tag);
    endtask

    // Expected output for absolute cycle c, based on cycles since reset release.
    task automatic push_model(input int c);
        int k, s, p, f;
        bit lit;
        logic [3:0] onehot;
        k = c - base;
        s = (k / 16) % 4;
        p = k % 16;
        f = k / 64;
        lit = (p != 0) && ((p / 4) <= sc_bright)
              && !(sc_blink[s] && ((f / 2) % 2 == 1))
              && (sc_seg[s] != 8'hFF);
        onehot = 4'b0001 << s;
        push_exp(c, lit ? ~onehot : 4'hF, lit ? sc_seg[s] : 8'hFF, (k > 0) && (k % 64 == 0));
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        cur_tag = "reset";
        for (int i = 1; i <= n; i++) push_exp(cyc + i, 4'hF, 8'hFF, 1'b0);
        repeat (n) @(negedge clk);
        resetn = 1'b1;
        base = cyc + 1;
        for (int i = 0; i < 4; i++) sc_seg[i] = 8'hC0;
    endtask

    task automatic do_load(input logic [15:0] num, input logic [3:0] dp,
                           input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3);
        num_in = num;
        dp_in = dp;
        load = 1'b1;
        push_model(cyc + 1);
        sc_seg[0] = s0;
        sc_seg[1] = s1;
        sc_seg[2] = s2;
        sc_seg[3] = s3;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 1; i <= n; i++) push_model(cyc + i);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compare the DUT outputs against the queued entry for this cycle.
    always @(negedge clk) begin
        if (q_cyc.size() > 0) begin
            if (q_cyc[0] < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s missed: entry for cyc=%0d still queued at cyc=%0d", q_tag[0], q_cyc[0], cyc);
                void'(q_cyc.pop_front());
                void'(q_an.pop_front());
                void'(q_c.pop_front());
                void'(q_fd.pop_front());
                void'(q_tag.pop_front());
            end else if (q_cyc[0] == cyc) begin
                n_checks++;
                if (an_out !== q_an[0] || c_out !== q_c[0] || frame_done !== q_fd[0]) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got an_out=%h c_out=%h frame_done=%b, want an_out=%h c_out=%h frame_done=%b",
                             q_tag[0], cyc, an_out, c_out, frame_done, q_an[0], q_c[0], q_fd[0]);
                end
                void'(q_cyc.pop_front());
                void'(q_an.pop_front());
                void'(q_c.pop_front());
                void'(q_fd.pop_front());
                void'(q_tag.pop_front());
            end
        end
    end

    initial begin
        // Reset held for 3 cycles, then the scan runs on a zero register.
        do_reset(3);
        cur_tag = "scan";
        run(130);

        // Hex decode with a decimal point on digit 1.
        cur_tag = "hex_load";
        do_load(16'hA5C0, 4'b0010, 8'hC0, 8'h46, 8'h92, 8'h88);
        run(64);
        cur_tag = "no_load_change";
        num_in = 16'hFFFF;
        dp_in = 4'hF;
        run(64);

        // Leading-zero blanking; blanked digits also drop their dp.
        cur_tag = "lz_0030";
        blank_lz = 1'b1;
        do_load(16'h0030, 4'b1100, 8'hC0, 8'hB0, 8'hFF, 8'hFF);
        run(64);
        cur_tag = "lz_0000";
        do_load(16'h0000, 4'b0000, 8'hC0, 8'hFF, 8'hFF, 8'hFF);
        run(64);

        // PWM duty, including changes that land mid-slot.
        cur_tag = "pwm_b0";
        do_load(16'h1234, 4'b0000, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        blank_lz = 1'b0;
        brightness = 2'd0;
        sc_bright = 0;
        run(64);
        cur_tag = "pwm_b1";
        brightness = 2'd1;
        sc_bright = 1;
        run(37);
        cur_tag = "pwm_b2";
        brightness = 2'd2;
        sc_bright = 2;
        run(50);
        cur_tag = "pwm_b3";
        brightness = 2'd3;
        sc_bright = 3;
        run(20);

        // Blink on digit 1 over six frames, starting from reset.
        blink_mask = 4'b0010;
        sc_blink = 4'b0010;
        do_reset(2);
        cur_tag = "blink";
        do_load(16'h8E1D, 4'b0000, 8'hA1, 8'hF9, 8'h86, 8'h80);
        run(383);

        // Reset in slot 2 of frame 3 while blink phase is 1; the scan restarts cleanly.
        do_reset(2);
        cur_tag = "pre_midreset";
        do_load(16'h1234, 4'b0001, 8'h19, 8'hB0, 8'hA4, 8'hF9);
        run(228);
        do_reset(2);
        cur_tag = "post_midreset";
        run(192);

        repeat (3) @(negedge clk);
        n_checks++;
        if (q_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", q_cyc.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
